// File: rtl/axi4l2core_pipe.sv
// axi4l2core_pipe: pipelined AXI4-Lite slave to core (req/gnt/rvalid) bridge.
// Up to DEPTH transactions may be outstanding, counting both those in flight
// at the core and responses still waiting in the per-channel response FIFOs.
// Reads and writes are arbitrated round-robin.
// Optional feature macro: AXI4L2CORE_PIPE_ALIGN_CHECK_EN. When defined,
// misaligned addresses are answered locally with SLVERR instead of being
// forwarded to the core.
module axi4l2core_pipe #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  core_req,
    input  logic                  core_gnt,
    output logic                  core_we,
    output logic [DATA_W/8-1:0]   core_be,
    output logic [ADDR_W-1:0]     core_addr,
    output logic [DATA_W-1:0]     core_wdata,
    input  logic                  core_rvalid,
    input  logic                  core_err,
    input  logic [DATA_W-1:0]     core_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                               input logic push,
                                               input logic pop);
        case ({push, pop})
            2'b10:   return c + 1'b1;
            2'b01:   return c - 1'b1;
            default: return c;
        endcase
    endfunction

    // Control state (reset) and next-state
    logic            last_rd_q, last_rd_d;
    logic [PW-1:0]   tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
    logic [PW-1:0]   rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
    logic [CW-1:0]   rq_cnt_q, rq_cnt_d;
    logic [PW-1:0]   bq_wp_q, bq_wp_d, bq_rp_q, bq_rp_d;
    logic [CW-1:0]   bq_cnt_q, bq_cnt_d;

    // Storage (data only, not reset)
    logic            tag_mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rq_data_q [0:DEPTH-1];
    logic [1:0]      rq_resp_q [0:DEPTH-1];
    logic [1:0]      bq_resp_q [0:DEPTH-1];

    logic            rd_cand, wr_cand, sel_rd, sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [SW-1:0]   occ;
    logic            credit, misaligned, accept, direct_err;
    logic            tag_push, tag_pop, head_rd;
    logic            rq_push, rq_pop, bq_push, bq_pop;
    logic [1:0]      push_resp;
    logic [DATA_W-1:0] rq_push_data;

    // Round-robin selection between the read and write candidates
    always_comb begin
        rd_cand  = arvalid;
        wr_cand  = awvalid && wvalid;
        sel_rd   = rd_cand && (!wr_cand || !last_rd_q);
        sel_wr   = wr_cand && !sel_rd;
        sel_addr = sel_rd ? araddr : awaddr;
        occ      = SW'(tag_cnt_q) + SW'(rq_cnt_q) + SW'(bq_cnt_q);
        credit   = occ < SW'(DEPTH);
    end

`ifdef AXI4L2CORE_PIPE_ALIGN_CHECK_EN
    localparam int OFF_W = $clog2(DATA_W / 8);
    assign misaligned = (sel_rd || sel_wr) && (sel_addr[OFF_W-1:0] != '0);
`else
    assign misaligned = 1'b0;
`endif

    // Core request and AXI accept; misaligned accesses bypass the core but
    // must wait for the tag FIFO to empty so the local error stays in order
    always_comb begin
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_be    = '0;
        core_addr  = '0;
        core_wdata = '0;
        accept     = 1'b0;
        direct_err = 1'b0;
        if ((sel_rd || sel_wr) && credit) begin
            if (misaligned) begin
                if (tag_cnt_q == '0) begin
                    accept     = 1'b1;
                    direct_err = 1'b1;
                end
            end else begin
                core_req   = 1'b1;
                core_we    = sel_wr;
                core_addr  = sel_addr;
                core_be    = sel_wr ? wstrb : '1;
                core_wdata = sel_wr ? wdata : '0;
                accept     = core_gnt;
            end
        end
    end

    assign arready = accept && sel_rd;
    assign awready = accept && sel_wr;
    assign wready  = accept && sel_wr;

    assign rvalid = (rq_cnt_q != '0);
    assign bvalid = (bq_cnt_q != '0);
    assign rdata  = rvalid ? rq_data_q[rq_rp_q] : '0;
    assign rresp  = rvalid ? rq_resp_q[rq_rp_q] : RESP_OKAY;
    assign bresp  = bvalid ? bq_resp_q[bq_rp_q] : RESP_OKAY;

    // Response routing and FIFO pointer/count next-state
    always_comb begin
        tag_push     = accept && !direct_err;
        tag_pop      = core_rvalid && (tag_cnt_q != '0);
        head_rd      = tag_mem_q[tag_rp_q];
        rq_push      = (tag_pop && head_rd) || (direct_err && sel_rd);
        bq_push      = (tag_pop && !head_rd) || (direct_err && sel_wr);
        push_resp    = (direct_err || core_err) ? RESP_SLVERR : RESP_OKAY;
        rq_push_data = direct_err ? '0 : core_rdata;
        rq_pop       = rvalid && rready;
        bq_pop       = bvalid && bready;

        last_rd_d = accept ? sel_rd : last_rd_q;
        tag_wp_d  = tag_push ? ptr_inc(tag_wp_q) : tag_wp_q;
        tag_rp_d  = tag_pop  ? ptr_inc(tag_rp_q) : tag_rp_q;
        tag_cnt_d = cnt_next(tag_cnt_q, tag_push, tag_pop);
        rq_wp_d   = rq_push ? ptr_inc(rq_wp_q) : rq_wp_q;
        rq_rp_d   = rq_pop  ? ptr_inc(rq_rp_q) : rq_rp_q;
        rq_cnt_d  = cnt_next(rq_cnt_q, rq_push, rq_pop);
        bq_wp_d   = bq_push ? ptr_inc(bq_wp_q) : bq_wp_q;
        bq_rp_d   = bq_pop  ? ptr_inc(bq_rp_q) : bq_rp_q;
        bq_cnt_d  = cnt_next(bq_cnt_q, bq_push, bq_pop);
    end

    // Control registers: arbiter flag, FIFO pointers and counts
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_rd_q <= 1'b0;
            tag_wp_q  <= '0;
            tag_rp_q  <= '0;
            tag_cnt_q <= '0;
            rq_wp_q   <= '0;
            rq_rp_q   <= '0;
            rq_cnt_q  <= '0;
            bq_wp_q   <= '0;
            bq_rp_q   <= '0;
            bq_cnt_q  <= '0;
        end else begin
            last_rd_q <= last_rd_d;
            tag_wp_q  <= tag_wp_d;
            tag_rp_q  <= tag_rp_d;
            tag_cnt_q <= tag_cnt_d;
            rq_wp_q   <= rq_wp_d;
            rq_rp_q   <= rq_rp_d;
            rq_cnt_q  <= rq_cnt_d;
            bq_wp_q   <= bq_wp_d;
            bq_rp_q   <= bq_rp_d;
            bq_cnt_q  <= bq_cnt_d;
        end
    end

    // FIFO storage writes
    always_ff @(posedge aclk) begin
        if (tag_push) begin
            tag_mem_q[tag_wp_q] <= sel_rd;
        end
        if (rq_push) begin
            rq_data_q[rq_wp_q] <= rq_push_data;
            rq_resp_q[rq_wp_q] <= push_resp;
        end
        if (bq_push) begin
            bq_resp_q[bq_wp_q] <= push_resp;
        end
    end

endmodule

// File: tb/tb_axi4l2core_pipe.sv
// Testbench for axi4l2core_pipe: directed cases plus randomized traffic
// against a word-memory reference model with a queue-based scoreboard.
module tb_axi4l2core_pipe;

    localparam int DEPTH = 2;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata, core_addr, core_wdata, core_rdata;
    logic [3:0]  wstrb, core_be;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        core_req, core_gnt, core_we, core_rvalid, core_err;

    axi4l2core_pipe #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we),
        .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rvalid(core_rvalid), .core_err(core_err), .core_rdata(core_rdata)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge aclk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: word memory, error rule and alignment rule
    logic [31:0] rmem [0:63];
    logic [31:0] cmem [0:63];

    function automatic bit is_mis(input logic [31:0] a);
`ifdef AXI4L2CORE_PIPE_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return a[5];
    endfunction

    // Core model: in-order responder with configurable grant rate and latency
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; int due; } creq_t;
    creq_t cq[$];
    int  gnt_pct = 100;
    int  lat_max = 0;
    bit  gnt_low = 0;

    always @(negedge aclk) begin
        creq_t r;
        if (aresetn && core_req && core_gnt) begin
            r.we = core_we; r.addr = core_addr; r.be = core_be; r.wd = core_wdata;
            r.due = cyc + 1 + $urandom_range(lat_max);
            cq.push_back(r);
        end
    end

    always @(posedge aclk) begin
        creq_t r;
        #1;
        core_rvalid = 1'b0;
        core_err    = 1'b0;
        core_rdata  = $urandom;
        core_gnt    = gnt_low ? 1'b0 : ($urandom_range(99) < gnt_pct);
        if (aresetn && cq.size() != 0 && cyc >= cq[0].due) begin
            r = cq.pop_front();
            core_rvalid = 1'b1;
            core_err    = is_err(r.addr);
            if (!r.we) core_rdata = cmem[r.addr[7:2]];
            else if (!is_err(r.addr))
                for (int b = 0; b < 4; b++)
                    if (r.be[b]) cmem[r.addr[7:2]][8*b +: 8] = r.wd[8*b +: 8];
        end
    end

    // Scoreboard: push expectations at AXI accept, pop/compare at AXI response
    logic [33:0] exp_r[$];
    logic [1:0]  exp_b[$];
    int          outstanding = 0;
    logic        r_hold = 1'b0;
    logic [33:0] r_hold_v;

    always @(negedge aclk) begin
        logic [33:0] er;
        logic [1:0]  eb;
        bit          issued;
        if (aresetn) begin
            issued = 0;
            if (r_hold) chk("r_stable", {rvalid, rresp, rdata}, {1'b1, r_hold_v});
            if (arvalid && arready) begin
                issued = 1;
                if (is_mis(araddr)) begin
                    chk("rd_issue_nocore", core_req, 1'b0);
                    er = {2'b10, 32'h0};
                end else begin
                    chk("rd_issue", {core_req, core_gnt, core_we, core_addr, core_be, core_wdata},
                        {1'b1, 1'b1, 1'b0, araddr, 4'hF, 32'h0});
                    er = {is_err(araddr) ? 2'b10 : 2'b00, rmem[araddr[7:2]]};
                end
                exp_r.push_back(er);
                outstanding++;
            end
            if (awvalid && wvalid && (awready || wready)) begin
                issued = 1;
                chk("wr_ready_pair", {awready, wready}, 2'b11);
                if (is_mis(awaddr)) begin
                    chk("wr_issue_nocore", core_req, 1'b0);
                    eb = 2'b10;
                end else begin
                    chk("wr_issue", {core_req, core_gnt, core_we, core_addr, core_be, core_wdata},
                        {1'b1, 1'b1, 1'b1, awaddr, wstrb, wdata});
                    eb = is_err(awaddr) ? 2'b10 : 2'b00;
                    if (!is_err(awaddr))
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) rmem[awaddr[7:2]][8*b +: 8] = wdata[8*b +: 8];
                end
                exp_b.push_back(eb);
                outstanding++;
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else chk("r_resp_data", {rresp, rdata}, exp_r.pop_front());
                outstanding--;
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("b_resp", bresp, exp_b.pop_front());
                outstanding--;
            end
            if (issued) chk("credit_limit", (outstanding <= DEPTH), 1'b1);
            r_hold   = rvalid && !rready;
            r_hold_v = {rresp, rdata};
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 200) begin
            tick(); n++;
        end
        chk(nm, (exp_r.size() == 0 && exp_b.size() == 0), 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {24'h0, 8'($urandom_range(255))} & 32'hFC;
        if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3, 1));
        return a;
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs, n, bad, n_ar, n_aw;
        bit seen, ar_hs, aw_hs;
        logic [31:0] a0;
        string order;
        for (int i = 0; i < 64; i++) begin
            rmem[i] = 32'hA500_0000 | i;
            cmem[i] = 32'hA500_0000 | i;
        end
        rmem[4] = 32'hDEADBEEF; cmem[4] = 32'hDEADBEEF;
        aresetn = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0;
        core_gnt = 0; core_rvalid = 0; core_err = 0; core_rdata = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_ready", {arready, awready, wready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_core",  {core_req, core_we}, 2'b00);
        chk("rst_resp",  {bresp, rresp}, 4'h0);
        chk("rst_rdata", rdata, 32'h0);
        tick(); aresetn = 1;
        tick();

        // Single read with 1-cycle core
        araddr = 32'h10; arvalid = 1; rready = 1;
        @(negedge aclk); chk("rd1_arready_c0", arready, 1'b1);
        tick(); arvalid = 0;
        @(negedge aclk); chk("rd1_core_rvalid_c1", core_rvalid, 1'b1);
        chk("rd1_rvalid_c1", rvalid, 1'b0);
        tick();
        @(negedge aclk); chk("rd1_rvalid_c2", rvalid, 1'b1);
        chk("rd1_rdata", rdata, 32'hDEADBEEF);
        chk("rd1_rresp", rresp, 2'b00);
        tick();

        // Single write with core error
        awaddr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge aclk); chk("wr1_ready_same_cycle", {awready, wready}, 2'b11);
        tick(); awvalid = 0; wvalid = 0;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge aclk);
            if (bvalid) begin seen = 1; chk("wr1_bresp", bresp, 2'b10); end
            tick(); n++;
        end
        chk("wr1_bvalid_seen", seen, 1'b1);
        drain("drain_wr1");

        // Alternating grants with both channels held
        araddr = 32'h40; awaddr = 32'h44; wdata = 32'h0BADF00D; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        order = ""; n = 0;
        while (order.len() < 4 && n < 40) begin
            @(negedge aclk);
            if (arready) order = {order, "R"};
            if (awready) order = {order, "W"};
            tick(); n++;
        end
        arvalid = 0; awvalid = 0; wvalid = 0;
        chk("arb_count", order.len(), 4);
        if (order.len() == 4) begin
            chk("arb_0", order[0], "R");
            chk("arb_1", order[1], "W");
            chk("arb_2", order[2], "R");
            chk("arb_3", order[3], "W");
        end
        drain("drain_arb");

        // Credit limit with read responses not drained
        arvalid = 1; araddr = 32'h0; rready = 0; hs = 0; n = 0;
        while (hs < 2 && n < 30) begin
            @(negedge aclk); if (arready) hs++;
            tick(); n++;
        end
        chk("cr_two_issued", hs, 2);
        bad = 0;
        repeat (6) begin @(negedge aclk); if (arready) bad++; tick(); end
        chk("cr_third_blocked", bad, 0);
        rready = 1;
        @(negedge aclk); chk("cr_rvalid", rvalid, 1'b1);
        tick(); rready = 0;
        seen = 0; n = 0;
        while (!seen && n < 5) begin
            @(negedge aclk); if (arready) seen = 1;
            tick(); n++;
        end
        chk("cr_third_after_pop", seen, 1'b1);
        arvalid = 0;
        drain("drain_credit");

        // Grant held low: request stable, nothing accepted
        gnt_low = 1; tick();
        arvalid = 1; araddr = 32'h80; awvalid = 1; wvalid = 1; awaddr = 32'h84;
        wdata = 32'hCAFE0001; wstrb = 4'h3;
        @(negedge aclk); a0 = core_addr;
        chk("gl_req", core_req, 1'b1);
        chk("gl_sel_wr", a0, 32'h84);
        bad = 0;
        repeat (5) begin
            if (arready || awready || wready) bad++;
            if (core_addr !== a0) bad++;
            tick(); @(negedge aclk);
        end
        chk("gl_stable_no_ready", bad, 0);
        gnt_low = 0; n_ar = 0; n_aw = 0; n = 0;
        while ((arvalid || awvalid) && n < 30) begin
            @(negedge aclk); ar_hs = arvalid && arready; aw_hs = awvalid && awready;
            tick(); n++;
            if (ar_hs) begin arvalid = 0; n_ar++; end
            if (aw_hs) begin awvalid = 0; wvalid = 0; n_aw++; end
        end
        chk("gl_both_granted", {n_ar[1:0], n_aw[1:0]}, 4'b0101);
        drain("drain_gl");

        // Misaligned read
        araddr = 32'h3; arvalid = 1; rready = 1;
        @(negedge aclk);
`ifdef AXI4L2CORE_PIPE_ALIGN_CHECK_EN
        chk("mis_no_core_req", core_req, 1'b0);
        chk("mis_arready", arready, 1'b1);
`else
        chk("mis_core_addr", {core_req, core_addr}, {1'b1, 32'h3});
`endif
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            if (arvalid && arready) seen = 1;
            tick(); n++;
            if (seen) arvalid = 0; else @(negedge aclk);
        end
        chk("mis_accepted", seen, 1'b1);
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge aclk);
            if (rvalid) begin
                seen = 1;
`ifdef AXI4L2CORE_PIPE_ALIGN_CHECK_EN
                chk("mis_resp", {rresp, rdata}, {2'b10, 32'h0});
`else
                chk("mis_resp", {rresp, rdata}, {2'b00, 32'hA5000000});
`endif
            end
            tick(); n++;
        end
        chk("mis_rvalid_seen", seen, 1'b1);
        drain("drain_mis");

        // Randomized traffic
        gnt_pct = 75; lat_max = 2;
        for (int c = 0; c < 800; c++) begin
            @(negedge aclk);
            ar_hs = arvalid && arready;
            aw_hs = awvalid && wvalid && awready;
            tick();
            if (!arvalid || ar_hs) begin
                arvalid = ($urandom_range(99) < 50);
                araddr  = rand_addr();
            end
            if (!awvalid || aw_hs) begin
                awvalid = ($urandom_range(99) < 50);
                wvalid  = awvalid;
                awaddr  = rand_addr();
                wdata   = $urandom;
                wstrb   = 4'($urandom_range(15));
            end
            rready = ($urandom_range(99) < 70);
            bready = ($urandom_range(99) < 70);
        end
        @(negedge aclk);
        ar_hs = arvalid && arready;
        aw_hs = awvalid && wvalid && awready;
        // finish any request already presented before stopping stimulus
        n = 0;
        while (((arvalid && !ar_hs) || (awvalid && !aw_hs)) && n < 50) begin
            tick();
            if (ar_hs) arvalid = 0;
            if (aw_hs) begin awvalid = 0; wvalid = 0; end
            rready = 1; bready = 1;
            @(negedge aclk);
            ar_hs = ar_hs || (arvalid && arready);
            aw_hs = aw_hs || (awvalid && wvalid && awready);
            n++;
        end
        tick();
        drain("drain_random");
        chk("outstanding_zero", outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
